// File: rtl/sigma_delta_decimator.sv
// Second-order CIC (sinc2) decimator for a 1-bit sigma-delta stream.
// Two integrators run at the accepted-bit rate, two combs run once per frame, and the result is scaled to 16-bit signed PCM.
module sigma_delta_decimator #(
   parameter int DECIM = 64
) (
   input  logic        CLOCK,
   input  logic        RESET,
   input  logic        BIT_IN,
   input  logic        BIT_VALID,
   output logic [15:0] DATAWORD_OUT,
   output logic        DATA_VALID,
   output logic        SAT_OUT,
   output logic        DBG_STATE
);

   localparam int L     = $clog2(DECIM);
   localparam int W     = 2 + 2 * L;
   localparam int SHIFT = 15 - 2 * L;

   typedef enum logic {S_FLUSH = 1'b0, S_RUN = 1'b1} state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_flush_cnt;
   logic                w_run;

   logic [L-1:0]        r_cnt;
   logic signed [W-1:0] r_int1;
   logic signed [W-1:0] r_int2;
   logic signed [W-1:0] r_d1;
   logic signed [W-1:0] r_c1;
   logic signed [W-1:0] r_d2;
   logic                r_fend;
   logic                r_c1_vld;

   logic [15:0]         r_word;
   logic                r_valid;
   logic                r_sat;

   logic signed [W-1:0] w_x;
   logic signed [W-1:0] w_int1_nxt;
   logic signed [W-1:0] w_int2_nxt;
   logic signed [W-1:0] w_c2;
   logic [16:0]         w_ext;
   logic [16:0]         w_scaled;
   logic                w_sat;
   logic [15:0]         w_word;

   assign w_x        = BIT_IN ? W'(1) : {W{1'b1}};
   assign w_int1_nxt = r_int1 + w_x;
   // Second integrator adds the already-updated first integrator so the frame's last bit is included.
   assign w_int2_nxt = r_int2 + w_int1_nxt;

   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         r_int1 <= '0;
         r_int2 <= '0;
         r_cnt  <= '0;
         r_fend <= 1'b0;
      end else begin
         r_fend <= BIT_VALID && (r_cnt == L'(DECIM - 1));
         if (BIT_VALID) begin
            r_int1 <= w_int1_nxt;
            r_int2 <= w_int2_nxt;
            r_cnt  <= r_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         r_d1     <= '0;
         r_c1     <= '0;
         r_d2     <= '0;
         r_c1_vld <= 1'b0;
      end else begin
         r_c1_vld <= r_fend;
         if (r_fend) begin
            r_c1 <= r_int2 - r_d1;
            r_d1 <= r_int2;
         end
         if (r_c1_vld) begin
            r_d2 <= r_c1;
         end
      end
   end

   // Comb output spans -DECIM^2..+DECIM^2; only the positive extreme overflows 16 bits.
   assign w_c2     = r_c1 - r_d2;
   assign w_ext    = {{(17 - W){w_c2[W-1]}}, w_c2};
   assign w_scaled = w_ext << SHIFT;
   assign w_sat    = ~w_scaled[16] & w_scaled[15];
   assign w_word   = w_sat ? 16'h7fff : w_scaled[15:0];

   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         r_state     <= S_FLUSH;
         r_flush_cnt <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == S_FLUSH && r_c1_vld) begin
            r_flush_cnt <= 1'b1;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (r_state == S_FLUSH && r_c1_vld && r_flush_cnt) begin
         w_state_nxt = S_RUN;
      end
   end

   always_comb begin
      w_run = (r_state == S_RUN);
   end

   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         r_word  <= '0;
         r_valid <= 1'b0;
         r_sat   <= 1'b0;
      end else begin
         r_valid <= r_c1_vld && w_run;
         if (r_c1_vld && w_run) begin
            r_word <= w_word;
            r_sat  <= w_sat;
         end
      end
   end

   assign DATAWORD_OUT = r_word;
   assign DATA_VALID   = r_valid;
   assign SAT_OUT      = r_sat;
   assign DBG_STATE    = (r_state == S_RUN);

endmodule

// File: tb/tb_sigma_delta_decimator.sv
// Bench for sigma_delta_decimator at DECIM = 64 and DECIM = 4 sharing one bitstream.
// Expected words come from a direct triangular-window (sinc2) convolution of the accepted bits.
module tb_sigma_delta_decimator;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        bit_in;
   logic        bit_valid;
   logic [15:0] word64, word4;
   logic        dv64, dv4, sat64, sat4, st64, st4;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   // Expected entry: {strobe cycle[31:0], sat, word[15:0]}
   logic [48:0] exp_q0[$];
   logic [48:0] exp_q1[$];
   logic [16:0] last0 = '0;
   logic [16:0] last1 = '0;

   int hist [2][255];
   int cnt [2];
   int flush [2];
   int dec_tab [2] = '{64, 4};
   int lg_tab [2]  = '{6, 2};

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   sigma_delta_decimator #(.DECIM(64)) u_dut64 (
      .CLOCK(clk), .RESET(rst_n), .BIT_IN(bit_in), .BIT_VALID(bit_valid),
      .DATAWORD_OUT(word64), .DATA_VALID(dv64), .SAT_OUT(sat64), .DBG_STATE(st64)
   );

   sigma_delta_decimator #(.DECIM(4)) u_dut4 (
      .CLOCK(clk), .RESET(rst_n), .BIT_IN(bit_in), .BIT_VALID(bit_valid),
      .DATAWORD_OUT(word4), .DATA_VALID(dv4), .SAT_OUT(sat4), .DBG_STATE(st4)
   );

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         for (int k = 0; k < 255; k++) hist[i][k] = 0;
         cnt[i]   = 0;
         flush[i] = 0;
      end
   endtask

   // Called at the negedge before the accepting posedge; strobe lands 2 edges after acceptance.
   task automatic model_accept(input logic b);
      for (int i = 0; i < 2; i++) begin
         for (int k = 254; k > 0; k--) hist[i][k] = hist[i][k-1];
         hist[i][0] = b ? 1 : -1;
         cnt[i]++;
         if (cnt[i] == dec_tab[i]) begin
            int          d;
            int          c;
            int          v;
            logic        s;
            logic [15:0] w;
            logic [48:0] e;
            d = dec_tab[i];
            c = 0;
            cnt[i] = 0;
            for (int k = 0; k < 2 * d - 1; k++)
               c += ((k < d) ? (k + 1) : (2 * d - 1 - k)) * hist[i][k];
            v = c * (1 << (15 - 2 * lg_tab[i]));
            s = (v > 32767);
            if (s) v = 32767;
            w = 16'(v);
            e = {32'(cyc + 3), s, w};
            if (flush[i] < 2) flush[i]++;
            else if (i == 0) exp_q0.push_back(e);
            else exp_q1.push_back(e);
         end
      end
   endtask

   task automatic drive(input logic b, input logic v);
      @(negedge clk);
      bit_in    = b;
      bit_valid = v;
      if (v) model_accept(b);
   endtask

   task automatic do_reset(input int n);
      @(posedge clk);
      #2;
      rst_n     = 1'b0;
      bit_valid = 1'b0;
      model_reset();
      repeat (n) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic check_port(input int i, input logic [15:0] w, input logic dv, input logic s);
      logic        have;
      logic        exp_dv;
      logic [48:0] fe;
      logic [16:0] last;
      last   = (i == 0) ? last0 : last1;
      have   = (i == 0) ? (exp_q0.size() != 0) : (exp_q1.size() != 0);
      fe     = '0;
      if (have) fe = (i == 0) ? exp_q0[0] : exp_q1[0];
      exp_dv = have && (fe[48:17] == 32'(cyc));
      vectors++;
      assert (dv === exp_dv) else begin
         miscompares++;
         $error("FAIL strobe_d%0d cyc=%0d observed=%0b expected=%0b", dec_tab[i], cyc, dv, exp_dv);
      end
      if (have && fe[48:17] <= 32'(cyc)) begin
         if (i == 0) void'(exp_q0.pop_front());
         else void'(exp_q1.pop_front());
      end
      if (exp_dv) last = fe[16:0];
      vectors++;
      assert ({s, w} === last) else begin
         miscompares++;
         $error("FAIL word_d%0d cyc=%0d observed sat/word=%0b/%h expected=%0b/%h",
                dec_tab[i], cyc, s, w, last[16], last[15:0]);
      end
      if (i == 0) last0 = last;
      else last1 = last;
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         vectors++;
         assert ({word64, dv64, sat64, word4, dv4, sat4} === 36'h0) else begin
            miscompares++;
            $error("FAIL reset_clear cyc=%0d observed w64=%h v64=%0b s64=%0b w4=%h v4=%0b s4=%0b expected all 0",
                   cyc, word64, dv64, sat64, word4, dv4, sat4);
         end
         exp_q0.delete();
         exp_q1.delete();
         last0 = '0;
         last1 = '0;
      end else begin
         check_port(0, word64, dv64, sat64);
         check_port(1, word4, dv4, sat4);
      end
   end

   initial begin
      bit_in    = 1'b0;
      bit_valid = 1'b0;
      rst_n     = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Constant +1: saturates to 32767
      for (int i = 0; i < 320; i++) drive(1'b1, 1'b1);

      // Constant -1: reaches -32768 without saturation
      do_reset(2);
      for (int i = 0; i < 320; i++) drive(1'b0, 1'b1);

      // Pattern 1,1,1,0 -> 16384
      do_reset(2);
      for (int i = 0; i < 320; i++) drive(1'((i % 4) != 3), 1'b1);

      // Pattern 1,0 -> 0
      do_reset(2);
      for (int i = 0; i < 320; i++) drive(1'((i % 2) == 0), 1'b1);

      // Pattern 1,1,1,0 with BIT_VALID toggling every cycle
      do_reset(2);
      for (int i = 0; i < 640; i++) drive(1'(((i / 2) % 4) != 3), 1'((i % 2) == 0));

      // Mid-frame reset after 100 accepted ones, then a fresh flush
      do_reset(2);
      for (int i = 0; i < 100; i++) drive(1'b1, 1'b1);
      do_reset(3);
      for (int i = 0; i < 260; i++) drive(1'b1, 1'b1);

      // Random bits with random gaps
      do_reset(2);
      for (int i = 0; i < 500; i++) drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));

      repeat (8) drive(1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/sigma_delta_decimator.md
SIGMA_DELTA_DECIMATOR -- requirements
Module: sigma_delta_decimator

Interface
REQ-001 The block SHALL have parameter DECIM, default 64, giving the decimation ratio; legal values are 4, 8, 16, 32, 64 and 128.
REQ-002 The block SHALL have port CLOCK  input  1  system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port RESET  input  1  reset: one clock, asynchronous, active-low.
REQ-004 The block SHALL have port BIT_IN  input  1  modulator bitstream sample (DATA_OUT of the modulator): 1 = +1, 0 = -1.
REQ-005 The block SHALL have port BIT_VALID  input  1  qualifies BIT_IN; the bit is accepted only on an edge where BIT_VALID = 1.
REQ-006 The block SHALL have port DATAWORD_OUT  output  16  signed decimated PCM word.
REQ-007 The block SHALL have port DATA_VALID  output  1  one-cycle strobe marking a new DATAWORD_OUT.
REQ-008 The block SHALL have port SAT_OUT  output  1  high together with DATA_VALID when the current word was clamped.

Function
REQ-009 The filter SHALL be a second-order CIC (sinc2) decimator: two integrators at input rate, two combs (differential delay 1) at output rate.
REQ-010 Integrator and comb width SHALL be W = 2 + 2*log2(DECIM) bits, two's complement, wrapping modulo 2^W with no saturation (W = 14 at DECIM = 64).
REQ-011 Each accepted bit SHALL update the integrators; cycles with BIT_VALID = 0 SHALL leave all integrator, counter and comb state unchanged.
REQ-012 A frame counter SHALL count accepted bits 0..DECIM-1 and wrap to 0; acceptance at count DECIM-1 ends a frame.
REQ-013 At frame end the combs SHALL evaluate once on the second-integrator value that includes the frame's last bit.
REQ-014 Comb output c (range -DECIM^2..+DECIM^2) SHALL be scaled as c * 2^(15 - 2*log2(DECIM)).
REQ-015 Scaled values above +32767 SHALL be clamped to +32767 with SAT_OUT = 1; values below -32768 do not occur; otherwise SAT_OUT = 0.
REQ-016 DATA_VALID SHALL rise exactly 2 clock cycles after the edge accepting a frame's last bit, for one cycle, with DATAWORD_OUT and SAT_OUT valid in that cycle.
REQ-017 Pipeline progress after frame end SHALL NOT depend on BIT_VALID.
REQ-018 DATAWORD_OUT and SAT_OUT SHALL hold their last values between strobes.
REQ-019 A control FSM SHALL have states FLUSH and RUN; reset enters FLUSH.
REQ-020 In FLUSH the first 2 frame results SHALL be computed internally but not strobed (DATA_VALID stays 0); after the second discarded frame the FSM moves to RUN.
REQ-021 In RUN every frame end SHALL produce exactly one DATA_VALID strobe.
REQ-022 When BIT_VALID is held high continuously, DATA_VALID SHALL occur exactly every DECIM cycles.
REQ-023 A bit accepted on the same edge that completes the previous frame's comb computation SHALL be counted in the new frame.

Reset
REQ-024 RESET low SHALL immediately clear integrators, comb delays, frame counter and pipeline, set DATAWORD_OUT = 0, DATA_VALID = 0 and SAT_OUT = 0, and force state FLUSH, independent of CLOCK.
REQ-025 Reset asserted mid-frame or mid-pipeline SHALL discard the partial frame and any pending strobe.
REQ-026 After RESET rises, the first accepted bit SHALL be count 0 of a new frame.

Verification
REQ-027 DECIM = 64, BIT_VALID = 1, BIT_IN = 1 constant -> no strobe for frames 1-2; every later strobe: DATAWORD_OUT = 32767, SAT_OUT = 1, spaced 64 cycles.
REQ-028 Same with BIT_IN = 0 constant -> DATAWORD_OUT = -32768, SAT_OUT = 0 from frame 3 on.
REQ-029 Repeating pattern 1,1,1,0 -> settled DATAWORD_OUT = 16384; pattern 1,0 -> DATAWORD_OUT = 0; SAT_OUT = 0 in both.
REQ-030 Pattern 1,1,1,0 with BIT_VALID toggling 1,0 every cycle -> identical word sequence, strobes every 128 cycles, each 2 cycles after the frame's last accepted bit.
REQ-031 RESET pulsed low for 3 cycles after 100 accepted bits of all-ones -> outputs 0 at once; no strobe until 3 full frames after release, then 32767.
REQ-032 DECIM = 4, all-ones -> settled DATAWORD_OUT = 32767 with SAT_OUT = 1; all-zeros -> -32768; DATA_VALID every 4 cycles.
